md_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit for the E stage of the pipelined MIPS core; owns the HI/LO register pair.
- Started by MULT/MULTU/DIV/DIVU in E. Written by MTHI/MTLO. Read by MFHI/MFLO through hi_o/lo_o.
- Drives busy_o, which the hazard unit uses to stall md-class instructions in D.
- Operation latency is a parameter rather than fixed logic.

---
 rtl/md_pkg.sv | 30 +++
 rtl/md_if.sv | 33 +++
 rtl/md_calc.sv | 83 ++++++++
 rtl/md_unit.sv | 94 +++++++++
 tb/tb_md_unit.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : md_pkg
//  Purpose  : Shared definitions for the multiply/divide unit: operation
//             encodings and the helper that sizes the latency counter.
//  Revision : 1.0  initial release
// ============================================================================
package md_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    // Counter must hold the larger of the two latencies.
    function automatic int cnt_width(input int mul_cycles, input int div_cycles);
        int max_cycles;
        max_cycles = (mul_cycles > div_cycles) ? mul_cycles : div_cycles;
        return $clog2(max_cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_if.sv
`default_nettype none
// ============================================================================
//  Module   : md_if
//  Purpose  : E-stage request / HI-LO result bundle of the multiply/divide
//             unit.
//  Ports    : start_i, op_i, src_a_i, src_b_i  (requester -> unit)
//             busy_o, hi_o, lo_o               (unit -> requester)
//  Revision : 1.0  initial release
// ============================================================================
interface md_if
    import md_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic              start_i;
    logic [OP_W-1:0]   op_i;
    logic [WIDTH-1:0]  src_a_i;
    logic [WIDTH-1:0]  src_b_i;
    logic              busy_o;
    logic [WIDTH-1:0]  hi_o;
    logic [WIDTH-1:0]  lo_o;

    modport master (
        output start_i, op_i, src_a_i, src_b_i,
        input  busy_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, src_a_i, src_b_i,
        output busy_o, hi_o, lo_o
    );
endinterface
`default_nettype wire

// File: rtl/md_calc.sv
`default_nettype none
// ============================================================================
//  Module   : md_calc
//  Purpose  : Combinational multiply/divide datapath. Produces the HI/LO pair
//             for MULT/MULTU/DIV/DIVU and flags a division by zero.
//  Ports    : i_op, i_a, i_b      operation and operands
//             o_hi, o_lo          result pair (zero for non-arithmetic ops)
//             o_div_zero          divide op with a zero divisor
//  Revision : 1.0  initial release
// ============================================================================
module md_calc
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic [OP_W-1:0]  i_op,
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    output logic      [WIDTH-1:0] o_hi,
    output logic      [WIDTH-1:0] o_lo,
    output logic                  o_div_zero
);
    localparam int W2 = 2 * WIDTH;

    logic [W2-1:0]    w_a_ext;
    logic [W2-1:0]    w_b_ext;
    logic [W2-1:0]    w_prod;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_signed_div;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_b_safe;
    logic [WIDTH-1:0] w_q_mag;
    logic [WIDTH-1:0] w_r_mag;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_r;

    always_comb begin
        w_is_mul     = (i_op == MD_MULT) || (i_op == MD_MULTU);
        w_is_div     = (i_op == MD_DIV)  || (i_op == MD_DIVU);
        w_signed_div = (i_op == MD_DIV);

        // Extending both operands to 2*WIDTH (sign or zero) makes the low
        // 2*WIDTH bits of an unsigned product correct for both flavours.
        if (i_op == MD_MULT) begin
            w_a_ext = {{WIDTH{i_a[WIDTH-1]}}, i_a};
            w_b_ext = {{WIDTH{i_b[WIDTH-1]}}, i_b};
        end else begin
            w_a_ext = {{WIDTH{1'b0}}, i_a};
            w_b_ext = {{WIDTH{1'b0}}, i_b};
        end
        w_prod = w_a_ext * w_b_ext;

        // Signed division runs on magnitudes. The most-negative dividend has
        // magnitude 2^(WIDTH-1), which is still exact as an unsigned value,
        // so MIN / -1 naturally wraps to MIN with a zero remainder.
        w_a_neg  = w_signed_div && i_a[WIDTH-1];
        w_b_neg  = w_signed_div && i_b[WIDTH-1];
        w_a_mag  = w_a_neg ? -i_a : i_a;
        w_b_mag  = w_b_neg ? -i_b : i_b;
        // Keep the divider away from a zero divisor; the result is discarded.
        w_b_safe = (i_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : w_b_mag;
        w_q_mag  = w_a_mag / w_b_safe;
        w_r_mag  = w_a_mag % w_b_safe;
        w_q      = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
        w_r      = w_a_neg ? -w_r_mag : w_r_mag;

        o_hi       = '0;
        o_lo       = '0;
        o_div_zero = w_is_div && (i_b == '0);
        if (w_is_mul) begin
            o_hi = w_prod[W2-1:WIDTH];
            o_lo = w_prod[WIDTH-1:0];
        end else if (w_is_div) begin
            o_hi = w_r;
            o_lo = w_q;
        end
    end
endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : md_unit
//  Purpose  : Multi-cycle multiply/divide unit owning the HI/LO registers.
//             A launch latches the result into pending registers and loads a
//             latency counter; HI/LO are updated only when the count expires.
//  Ports    : clk, reset (synchronous, active-high)
//             md  : md_if.slave (start_i, op_i, src_a_i, src_b_i,
//                                busy_o, hi_o, lo_o)
//  Revision : 1.0  initial release
// ============================================================================
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  wire logic clk,
    input  wire logic reset,
    md_if.slave       md
);
    localparam int CNT_W = cnt_width(MUL_CYCLES, DIV_CYCLES);

    localparam logic [CNT_W-1:0] c_mul_cnt = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] c_div_cnt = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_pend_hi;
    logic [WIDTH-1:0] r_pend_lo;
    logic             r_pend_ok;   // cleared for divide-by-zero: no commit

    logic [WIDTH-1:0] w_calc_hi;
    logic [WIDTH-1:0] w_calc_lo;
    logic             w_div_zero;
    logic             w_busy;

    md_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .i_op       (md.op_i),
        .i_a        (md.src_a_i),
        .i_b        (md.src_b_i),
        .o_hi       (w_calc_hi),
        .o_lo       (w_calc_lo),
        .o_div_zero (w_div_zero)
    );

    // Busy is derived purely from the registered counter.
    assign w_busy    = (r_cnt != '0);
    assign md.busy_o = w_busy;
    assign md.hi_o   = r_hi;
    assign md.lo_o   = r_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_ok <= 1'b0;
        end else if (w_busy) begin
            // Any start arriving here is dropped: the count runs undisturbed.
            r_cnt <= r_cnt - c_one;
            if (r_cnt == c_one && r_pend_ok) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
        end else if (md.start_i) begin
            case (md.op_i)
                MD_MULT, MD_MULTU: begin
                    r_cnt     <= c_mul_cnt;
                    r_pend_hi <= w_calc_hi;
                    r_pend_lo <= w_calc_lo;
                    r_pend_ok <= 1'b1;
                end
                MD_DIV, MD_DIVU: begin
                    r_cnt     <= c_div_cnt;
                    r_pend_hi <= w_calc_hi;
                    r_pend_lo <= w_calc_lo;
                    r_pend_ok <= !w_div_zero;
                end
                MD_MTHI: r_hi <= md.src_a_i;
                MD_MTLO: r_lo <= md.src_a_i;
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_md_unit
//  Purpose  : Directed self-checking bench for md_unit. Two instances: the
//             default latencies (5/10) and single-cycle latencies (1/1).
//             Expected results come from a 64-bit arithmetic model and are
//             queued at launch, then popped when busy_o falls.
//  Revision : 1.0  initial release
// ============================================================================
module tb_md_unit;
    import md_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] ohi;
        logic [31:0] olo;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst0;
    logic rst1;

    int n_assert = 0;
    int n_fail   = 0;

    exp_t        sb[$];
    logic [31:0] m_hi [2];
    logic [31:0] m_lo [2];
    int          mul_n [2];
    int          div_n [2];

    md_if #(.WIDTH(32)) bus0 ();
    md_if #(.WIDTH(32)) bus1 ();

    md_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut0 (
        .clk   (clk),
        .reset (rst0),
        .md    (bus0)
    );

    md_unit #(.WIDTH(32), .MUL_CYCLES(1), .DIV_CYCLES(1)) dut1 (
        .clk   (clk),
        .reset (rst1),
        .md    (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? bus0.busy_o : bus1.busy_o;
    endfunction

    function automatic logic [31:0] get_hi(input int sel);
        return (sel == 0) ? bus0.hi_o : bus1.hi_o;
    endfunction

    function automatic logic [31:0] get_lo(input int sel);
        return (sel == 0) ? bus0.lo_o : bus1.lo_o;
    endfunction

    task automatic drive(input int sel, input logic s, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (sel == 0) begin
            bus0.start_i = s; bus0.op_i = op; bus0.src_a_i = a; bus0.src_b_i = b;
        end else begin
            bus1.start_i = s; bus1.op_i = op; bus1.src_a_i = a; bus1.src_b_i = b;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Reference arithmetic in 64-bit integers.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input int sel);
        exp_t        e;
        logic [63:0] p;
        longint      sa;
        longint      sb_v;
        e.hi  = m_hi[sel];
        e.lo  = m_lo[sel];
        e.ohi = m_hi[sel];
        e.olo = m_lo[sel];
        e.cyc = 0;
        sa    = longint'($signed(a));
        sb_v  = longint'($signed(b));
        case (op)
            MD_MULT: begin
                p = sa * sb_v;
                e.hi = p[63:32]; e.lo = p[31:0]; e.cyc = mul_n[sel];
            end
            MD_MULTU: begin
                p = {32'h0, a} * {32'h0, b};
                e.hi = p[63:32]; e.lo = p[31:0]; e.cyc = mul_n[sel];
            end
            MD_DIV: begin
                e.cyc = div_n[sel];
                if (b != 32'h0) begin
                    p = sa / sb_v; e.lo = p[31:0];
                    p = sa % sb_v; e.hi = p[31:0];
                end
            end
            MD_DIVU: begin
                e.cyc = div_n[sel];
                if (b != 32'h0) begin
                    p = {32'h0, a} / {32'h0, b}; e.lo = p[31:0];
                    p = {32'h0, a} % {32'h0, b}; e.hi = p[31:0];
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    // Called at a negedge; returns at the next negedge with start cleared.
    task automatic do_op(input int sel, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        drive(sel, 1'b1, op, a, b);
        if (!get_busy(sel)) begin
            case (op)
                MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                    e = model(op, a, b, sel);
                    sb.push_back(e);
                    m_hi[sel] = e.hi;
                    m_lo[sel] = e.lo;
                end
                MD_MTHI: m_hi[sel] = a;
                MD_MTLO: m_lo[sel] = a;
                default: ;
            endcase
        end
        @(negedge clk);
        drive(sel, 1'b0, MD_NONE, 32'h0, 32'h0);
    endtask

    // Counts busy cycles (pre already elapsed), checks HI/LO hold, then the
    // committed result against the popped scoreboard entry.
    task automatic wait_done(input int sel, input int pre, input string tag);
        exp_t e;
        int   n;
        n_assert++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL %s_sb: observed 0 queued results expected at least 1", tag);
        end
        if (sb.size() == 0) return;
        e = sb.pop_front();
        n = pre;
        while (get_busy(sel) && n < 200) begin
            n++;
            chk({tag, "_hold_hi"}, get_hi(sel), e.ohi);
            chk({tag, "_hold_lo"}, get_lo(sel), e.olo);
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'(e.cyc));
        chk({tag, "_hi"}, get_hi(sel), e.hi);
        chk({tag, "_lo"}, get_lo(sel), e.lo);
    endtask

    initial begin
        exp_t dummy;
        mul_n[0] = 5; div_n[0] = 10;
        mul_n[1] = 1; div_n[1] = 1;
        m_hi[0] = 32'h0; m_lo[0] = 32'h0;
        m_hi[1] = 32'h0; m_lo[1] = 32'h0;
        drive(0, 1'b0, MD_NONE, 32'h0, 32'h0);
        drive(1, 1'b0, MD_NONE, 32'h0, 32'h0);
        rst0 = 1'b1;
        rst1 = 1'b1;
        repeat (3) @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);

        chk("reset_hi", get_hi(0), 32'h0);
        chk("reset_lo", get_lo(0), 32'h0);
        chk("reset_busy", 32'(get_busy(0)), 32'h0);

        // Signed and unsigned multiply
        do_op(0, MD_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(0, 0, "mult_neg3x5");
        chk("mult_hi_const", get_hi(0), 32'hFFFF_FFFF);
        chk("mult_lo_const", get_lo(0), 32'hFFFF_FFF1);

        do_op(0, MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_done(0, 0, "multu");
        chk("multu_hi_const", get_hi(0), 32'h0000_0001);
        chk("multu_lo_const", get_lo(0), 32'hFFFF_FFFE);

        // Signed divide, truncation toward zero
        do_op(0, MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(0, 0, "div_neg7by2");
        chk("div_lo_const", get_lo(0), 32'hFFFF_FFFD);
        chk("div_hi_const", get_hi(0), 32'hFFFF_FFFF);

        // Divide by zero leaves HI/LO untouched
        do_op(0, MD_MTHI, 32'h1234_5678, 32'h0);
        do_op(0, MD_MTLO, 32'h1234_5678, 32'h0);
        do_op(0, MD_DIVU, 32'd7, 32'd0);
        wait_done(0, 0, "divu_by0");
        chk("divu0_hi_const", get_hi(0), 32'h1234_5678);
        chk("divu0_lo_const", get_lo(0), 32'h1234_5678);

        // Overflow case wraps
        do_op(0, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0, 0, "div_min_by_m1");
        chk("divmin_lo_const", get_lo(0), 32'h8000_0000);
        chk("divmin_hi_const", get_hi(0), 32'h0);

        do_op(0, MD_DIVU, 32'hFFFF_FFF9, 32'd2);
        wait_done(0, 0, "divu_big");
        do_op(0, MD_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_done(0, 0, "div_7by_m2");

        // MTHI then MTLO on consecutive edges
        do_op(0, MD_MTHI, 32'hCAFE_BABE, 32'h0);
        chk("mthi_hi", get_hi(0), 32'hCAFE_BABE);
        chk("mthi_busy", 32'(get_busy(0)), 32'h0);
        do_op(0, MD_MTLO, 32'h0000_0001, 32'h0);
        chk("mtlo_lo", get_lo(0), 32'h0000_0001);
        chk("mtlo_hi_kept", get_hi(0), 32'hCAFE_BABE);
        chk("mtlo_busy", 32'(get_busy(0)), 32'h0);

        // Starts while busy are ignored
        do_op(0, MD_MULT, 32'd7, 32'd6);
        drive(0, 1'b1, MD_DIV, 32'd100, 32'd3);
        @(negedge clk);
        drive(0, 1'b1, MD_MTLO, 32'd55, 32'h0);
        @(negedge clk);
        drive(0, 1'b0, MD_NONE, 32'h0, 32'h0);
        wait_done(0, 2, "mult_ignore");
        @(negedge clk);
        chk("ignore_no_relaunch", 32'(get_busy(0)), 32'h0);
        chk("ignore_lo_kept", get_lo(0), 32'd42);

        // Reset mid-operation aborts without commit
        do_op(0, MD_MULT, 32'd9, 32'd9);
        @(negedge clk);
        @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        dummy = sb.pop_back();
        m_hi[0] = 32'h0;
        m_lo[0] = 32'h0;
        chk("abort_hi", get_hi(0), 32'h0);
        chk("abort_lo", get_lo(0), 32'h0);
        chk("abort_busy", 32'(get_busy(0)), 32'h0);
        repeat (8) @(negedge clk);
        chk("abort_late_hi", get_hi(0), 32'h0);
        chk("abort_late_lo", get_lo(0), 32'h0);
        chk("abort_late_busy", 32'(get_busy(0)), 32'h0);

        // Single-cycle latencies, back-to-back launches
        do_op(1, MD_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(1, 0, "p1_mult");
        do_op(1, MD_MULT, 32'h0001_0000, 32'h0001_0000);
        wait_done(1, 0, "p1_mult_b2b");
        do_op(1, MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(1, 0, "p1_div");
        do_op(1, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1, 0, "p1_multu");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected finish within limit");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
